// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and FSM state encoding for the UART receiver with FIFO.
// Optional parity build: define UART_RX_PARITY_EN.
package uart_rx_fifo_pkg;

  localparam int OS_RATE = 16;
  localparam int OS_MID = 7;
  localparam int DEF_CLK_DIV = 326;

  localparam logic [3:0] S_MID = 4'(OS_MID);
  localparam logic [3:0] S_LAST = 4'(OS_RATE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO with registered empty/full flags.
// A write while full is accepted only if a read frees a slot the same cycle.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic do_rd;
  logic do_wr;

  always_comb begin
    do_rd = rd & ~empty;
    do_wr = wr & (~full | do_rd);
    drop = wr & ~do_wr;
    count_n = count + CW'(do_wr) - CW'(do_rd);
  end

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wdata;
        wptr <= wptr + AW'(1);
      end
      if (do_rd) rptr <= rptr + AW'(1);
      count <= count_n;
      empty <= (count_n == '0);
      full <= (count_n == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver feeding a small byte FIFO.
// Even-parity frame checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart_rx,
  input  logic                 i_rd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_parity_err
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NW = $clog2(DATA_BITS + 1);

  logic sync1;
  logic sync2;
  logic [TW-1:0] tcnt;
  logic tick;
  state_t state;
  logic [3:0] s;
  logic [NW-1:0] n;
  logic [DATA_BITS-1:0] shreg;
  logic push;
  logic frame_err;
  logic drop;
  logic overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      sync2 <= sync1;
    end
  end

  assign tick = (tcnt == TW'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) tcnt <= '0;
    else if (tick) tcnt <= '0;
    else tcnt <= tcnt + TW'(1);
  end

`ifdef UART_RX_PARITY_EN
  logic pbad;
  logic par_err;
  assign o_parity_err = par_err;
`else
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    push <= 1'b0;
    frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err <= 1'b0;
`endif
    if (i_rst) begin
      state <= ST_IDLE;
      s <= '0;
      n <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      pbad <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!sync2) begin
            state <= ST_START;
            s <= '0;
`ifdef UART_RX_PARITY_EN
            pbad <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (tick) begin
            if (s == S_MID) begin
              s <= '0;
              n <= '0;
              state <= sync2 ? ST_IDLE : ST_DATA;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (s == S_LAST) begin
              s <= '0;
              shreg <= {sync2, shreg[DATA_BITS-1:1]};
              n <= n + NW'(1);
              if (n == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (s == S_LAST) begin
              s <= '0;
              pbad <= sync2 ^ (^shreg);
              state <= ST_STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (s == S_LAST) begin
              s <= '0;
              state <= ST_IDLE;
              // frame error outranks a parity mismatch
              if (!sync2) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              else if (pbad) par_err <= 1'b1;
`endif
              else push <= 1'b1;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .wr(push),
    .rd(i_rd),
    .wdata(shreg),
    .rdata(o_data),
    .empty(o_empty),
    .full(o_full),
    .drop(drop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end

  assign o_rx_done = push & ~drop;
  assign o_frame_err = frame_err;
  assign o_overrun = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed table, corner sequences, random frames
// checked against a queue-based model of the received byte stream.
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 4;
  localparam int DB = 8;
  localparam int DEPTH = 4;
  localparam int BIT = CLK_DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;

  logic clk = 1'b0;
  logic rst;
  logic line;
  logic rd;
  logic [DB-1:0] data;
  logic empty, full, done, ferr, ovr, perr;

  uart_rx_fifo #(
    .CLK_DIV(CLK_DIV),
    .DATA_BITS(DB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_uart_rx(line),
    .i_rd(rd),
    .o_data(data),
    .o_empty(empty),
    .o_full(full),
    .o_rx_done(done),
    .o_frame_err(ferr),
    .o_overrun(ovr),
    .o_parity_err(perr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int n_done = 0, n_ferr = 0, n_perr = 0;
  int e_done = 0, e_ferr = 0, e_perr = 0;
  logic [7:0] q[$];
  bit ovr_exp = 0;

  always @(negedge clk) begin
    if (done) n_done++;
    if (ferr) n_ferr++;
    if (perr) n_perr++;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clocks(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(logic [7:0] d, bit stop, bit par);
    line = 1'b0;
    clocks(BIT);
    for (int i = 0; i < DB; i++) begin
      line = d[i];
      clocks(BIT);
    end
    if (PAR == 1) begin
      line = par;
      clocks(BIT);
    end
    if (stop) begin
      line = 1'b1;
      clocks(BIT);
    end else begin
      line = 1'b0;
      clocks(BIT * 3 / 4);
      line = 1'b1;
      clocks(BIT / 4);
    end
    line = 1'b1;
    clocks(BIT / 2);
  endtask

  // Receiver behaviour from the frame rules, independent of the RTL.
  task automatic model(logic [7:0] d, bit stop, bit pok, bit rd_push);
    if (!stop) e_ferr++;
    else if (PAR == 1 && !pok) e_perr++;
    else if (q.size() < DEPTH) begin
      q.push_back(d);
      e_done++;
    end else if (rd_push) begin
      void'(q.pop_front());
      q.push_back(d);
    end else ovr_exp = 1'b1;
  endtask

  function automatic bit pbit(logic [7:0] d, bit pok);
    return pok ? ^d : ~^d;
  endfunction

  task automatic frame(logic [7:0] d, bit stop, bit pok);
    send(d, stop, pbit(d, pok));
    model(d, stop, pok, 1'b0);
    chk("done_cnt", n_done, e_done);
    chk("ferr_cnt", n_ferr, e_ferr);
    chk("perr_cnt", n_perr, e_perr);
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
  endtask

  task automatic pop();
    if (q.size() > 0) begin
      chk("head", data, q[0]);
      chk("empty_pre", empty, 0);
    end else begin
      chk("empty_pre", empty, 1);
    end
    rd = 1'b1;
    clocks(1);
    rd = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    chk("empty_post", empty, q.size() == 0);
    chk("full_post", full, q.size() == DEPTH);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    line = 1'b1;
    rd = 1'b0;
    clocks(3);
    rst = 1'b0;
    q.delete();
    ovr_exp = 1'b0;
    clocks(2);
  endtask

  typedef struct {
    logic [7:0] d;
    bit stop;
    bit done;
    bit ferr;
    logic [7:0] head;
    bit full;
    bit ovr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int t;
    bit got;
    int b_done, b_ferr;
    logic [7:0] rb;
    bit rs, rp;

    tbl[0] = '{8'h55, 1, 1, 0, 8'h55, 0, 0};
    tbl[1] = '{8'hA3, 0, 0, 1, 8'h55, 0, 0};
    tbl[2] = '{8'h3C, 1, 1, 0, 8'h55, 0, 0};
    tbl[3] = '{8'h01, 1, 1, 0, 8'h55, 0, 0};
    tbl[4] = '{8'h02, 1, 1, 0, 8'h55, 1, 0};
    tbl[5] = '{8'h03, 1, 0, 0, 8'h55, 1, 1};

    rst = 1'b1;
    line = 1'b1;
    rd = 1'b0;
    do_reset();

    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_data", data, 0);
    chk("rst_done", done, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_perr", perr, 0);
    chk("rst_ovr", ovr, 0);

    // first byte: completion time about 9.5 bit-times after the start edge
    got = 0;
    t = 0;
    fork
      send(8'h55, 1, pbit(8'h55, 1));
      begin
        for (int i = 0; i < 2000 && !got; i++) begin
          @(negedge clk);
          t = i;
          if (done) got = 1;
        end
      end
    join
    model(8'h55, 1, 1, 0);
    chk("done_seen", got, 1);
    chk("done_time", (t >= (2*NB-1)*BIT/2 - 24) && (t <= (2*NB-1)*BIT/2 + 24), 1);
    chk("done_cnt", n_done, e_done);
    chk("data_55", data, 8'h55);
    pop();

    // short low glitch is rejected silently
    line = 1'b0;
    clocks(16);
    line = 1'b1;
    clocks(200);
    chk("glitch_done", n_done, e_done);
    chk("glitch_ferr", n_ferr, e_ferr);
    chk("glitch_empty", empty, 1);
    frame(8'h3C, 1, 1);
    pop();

    // directed table
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b_done = n_done;
      b_ferr = n_ferr;
      send(tbl[i].d, tbl[i].stop, pbit(tbl[i].d, 1));
      model(tbl[i].d, tbl[i].stop, 1, 0);
      chk("tbl_done", n_done - b_done, tbl[i].done);
      chk("tbl_ferr", n_ferr - b_ferr, tbl[i].ferr);
      chk("tbl_head", data, tbl[i].head);
      chk("tbl_full", full, tbl[i].full);
      chk("tbl_ovr", ovr, tbl[i].ovr);
    end
    for (int i = 0; i < 5; i++) pop();

    // five bytes, no reads: fifth is dropped and overrun sticks
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      rb = 8'(i);
      frame(rb, 1, 1);
      chk("ovr_seq", ovr, ovr_exp);
    end
    chk("ovr_set", ovr, 1);
    for (int i = 0; i < 4; i++) pop();
    chk("ovr_kept", ovr, 1);
    do_reset();
    chk("ovr_clr", ovr, 0);

    // read in the push cycle while full
    for (int i = 1; i <= 4; i++) begin
      rb = 8'(i * 16);
      frame(rb, 1, 1);
    end
    got = 0;
    fork
      send(8'h77, 1, pbit(8'h77, 1));
      begin
        for (int i = 0; i < 2000 && !got; i++) begin
          @(negedge clk);
          if (dut.push) begin
            got = 1;
            chk("head_rdpush", data, q[0]);
            #1 rd = 1'b1;
            #1 chk("done_rdpush", done, 1);
            chk("ovr_rdpush", ovr, 0);
            @(negedge clk);
            rd = 1'b0;
          end
        end
      end
    join
    model(8'h77, 1, 1, 1);
    chk("push_seen", got, 1);
    chk("full_rdpush", full, 1);
    chk("ovr_after", ovr, 0);
    for (int i = 0; i < 4; i++) pop();

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1, 0);
    chk("par_bad_empty", empty, 1);
    frame(8'h07, 1, 1);
    chk("par_ok_data", data, 8'h07);
    pop();
    frame(8'h5A, 0, 0);
`endif

    // reset mid-frame abandons it
    b_done = n_done;
    @(negedge clk);
    line = 1'b0;
    clocks(BIT * 4);
    rst = 1'b1;
    line = 1'b1;
    clocks(2);
    rst = 1'b0;
    q.delete();
    ovr_exp = 1'b0;
    clocks(BIT * 12);
    chk("midrst_done", n_done, b_done);
    chk("midrst_ferr", n_ferr, e_ferr);
    chk("midrst_perr", n_perr, e_perr);
    chk("midrst_empty", empty, 1);

    // random frames and reads against the model
    for (int k = 0; k < 14; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      rp = (PAR == 0) || ($urandom_range(0, 5) != 0);
      frame(rb, rs, rp);
      chk("rnd_ovr", ovr, ovr_exp);
      repeat ($urandom_range(0, 2)) pop();
    end
    while (q.size() > 0) pop();
    pop();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 326, system clocks per 16x oversample tick (50 MHz, 9600 baud).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer depth (power of 2).
REQ-004 SHALL have port i_clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_uart_rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port i_rd  input  1  pop request, one byte per asserted cycle.
REQ-008 SHALL have port o_data  output  DATA_BITS  FIFO head byte, valid while o_empty=0.
REQ-009 SHALL have port o_empty  output  1  FIFO holds no bytes.
REQ-010 SHALL have port o_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port o_rx_done  output  1  one-cycle pulse when a good byte is pushed.
REQ-012 SHALL have port o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-013 SHALL have port o_overrun  output  1  sticky; a good byte arrived while FIFO full.
REQ-014 SHALL have port o_parity_err  output  1  one-cycle pulse on parity mismatch.

Function
REQ-015 SHALL pass i_uart_rx through a 2-flop synchronizer (both flops reset to 1); all sampling uses its output.
REQ-016 SHALL free-run a tick counter 0..CLK_DIV-1, asserting an internal tick for one cycle at CLK_DIV-1, then wrapping to 0.
REQ-017 SHALL implement FSM IDLE, START, DATA, PARITY, STOP, with a 4-bit tick counter s and a bit counter n.
REQ-018 IDLE: on synchronized line = 0, SHALL go to START with s=0.
REQ-019 START: on tick with s=7, SHALL go to DATA (s=0, n=0) if the line is still 0, else return to IDLE (glitch reject); otherwise s++ on tick.
REQ-020 DATA: on tick with s=15, SHALL shift the line into the shift register LSB-first, s=0, n++; after DATA_BITS samples go to PARITY (macro on) or STOP.
REQ-021 PARITY: on tick with s=15, SHALL compare the line with even parity of the data bits, latch mismatch, go to STOP.
REQ-022 STOP: on tick with s=15, line=1 and no parity mismatch SHALL push the byte and pulse o_rx_done; line=0 SHALL discard the byte and pulse o_frame_err; then return to IDLE.
REQ-023 Parity mismatch with a good stop bit SHALL discard the byte and pulse o_parity_err; frame error takes precedence if both.
REQ-024 FIFO SHALL be first-word-fall-through; o_data = mem[rd_ptr]; pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-025 i_rd while o_empty=1 SHALL be ignored; pointers and count unchanged.
REQ-026 Push while full without i_rd SHALL drop the byte, suppress o_rx_done, and set o_overrun until reset.
REQ-027 Push and i_rd in the same cycle while full SHALL both occur, count unchanged, no overrun; while empty the push occurs and the pop is ignored.
REQ-028 o_empty/o_full SHALL update the cycle after a push/pop edge (registered flags).

Reset
REQ-029 i_rst SHALL return FSM to IDLE and clear s, n, shift register, tick counter, pointers, count, and o_overrun; set synchronizer flops to 1.
REQ-030 After reset: o_empty=1, o_full=0, o_data=0, o_rx_done=o_frame_err=o_parity_err=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no push and no error pulse.

Configuration
REQ-032 With UART_RX_PARITY_EN defined, SHALL include the PARITY state and even-parity check (frame = start + DATA_BITS + parity + stop).
REQ-033 Without UART_RX_PARITY_EN, PARITY state and its logic SHALL be absent, DATA goes directly to STOP, and o_parity_err is tied 0.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding, the oversample constants (16, mid-point 7), and the default CLK_DIV.
REQ-035 FIFO SHALL be a separate sub-module rx_fifo (parameters WIDTH, DEPTH); synchronizer, tick generator, and FSM stay in uart_rx_fifo.

Verification (CLK_DIV=4, bit = 64 clocks)
REQ-036 Frame 0x55, good stop -> o_rx_done pulse about 9.5 bit-times after the start edge, o_empty=0, o_data=0x55; i_rd one cycle -> o_empty=1.
REQ-037 Line low 2 bit-times' worth of clocks? no: low only 16 clocks (below mid-point) -> no push, FSM back in IDLE, no error pulse.
REQ-038 Frame 0xA3 with stop bit 0 -> o_frame_err pulse, FIFO still empty, next frame 0x3C received correctly.
REQ-039 Five frames 0x01..0x05, no reads -> o_full=1 after 4th, 5th dropped, o_overrun=1; reads return 0x01..0x04 in order; reset clears o_overrun.
REQ-040 FIFO full, i_rd asserted in the push cycle of 0x77 -> count stays 4, no overrun, 0x77 is last out.
REQ-041 UART_RX_PARITY_EN: 0x07 with parity bit 0 -> o_parity_err pulse, no push; with parity bit 1 -> push 0x07.
